// File: rtl/sub_serial_pkg.sv
// Shared state encoding for the bit-serial subtractor.
package sub_serial_pkg;

  localparam int unsigned STATE_W = 2;

  // 2'd3 is never entered; the FSM decodes it exactly like IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fsub_bit.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module fsub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: a - b one bit per clock, LSB first, IDLE/SUB/DONE control.
// Optional SUB_SERIAL_SAT_EN: a negative result saturates the difference to zero.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    count;
  logic             d_c;
  logic             bout_c;
  logic             idle_c;
  logic             last_c;

  fsub_bit u_fsub_bit (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (borrow),
    .d    (d_c),
    .bout (bout_c)
  );

  // Anything other than SUB/DONE behaves as IDLE, including the unused code.
  assign idle_c = (state != SUB) && (state != DONE);
  assign last_c = (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SUB: begin
        if (last_c)   state_next = DONE;
        else if (!en) state_next = IDLE;
      end
      DONE: begin
        if (en) state_next = IDLE;
      end
      default: begin
        state_next = en ? SUB : IDLE;
      end
    endcase
  end

  // Datapath: load on start, shift one bit per SUB cycle, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      out    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state_next == DONE);
      if (idle_c && en) begin
        a_reg  <= a;
        b_reg  <= b;
        out    <= '0;
        borrow <= 1'b0;
        count  <= '0;
      end else if (state == SUB) begin
        a_reg  <= a_reg >> 1;
        b_reg  <= b_reg >> 1;
        borrow <= bout_c;
        count  <= count + CW'(1);
`ifdef SUB_SERIAL_SAT_EN
        if (last_c && bout_c) out <= '0;
        else                  out <= {d_c, out[WIDTH-1:1]};
`else
        out <= {d_c, out[WIDTH-1:1]};
`endif
      end
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial (WIDTH=8); honours SUB_SERIAL_SAT_EN.
module tb_sub_serial;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;
  logic       borrow;
  logic       done;

  int tests;
  int failures;

  logic [8:0] sb_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_borrow;
  } vec_t;

  vec_t vecs[8];

  sub_serial #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .out    (out),
    .borrow (borrow),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sat_adj(input logic [7:0] o, input logic bw);
`ifdef SUB_SERIAL_SAT_EN
    return bw ? 8'h00 : o;
`else
    return bw ? o : o;
`endif
  endfunction

  // Counts posedges (sampling #1 after) until done, bounded by max_cyc.
  task automatic wait_done(input int max_cyc, output int lat);
    lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pop_and_compare(input string name, input int lat, input int exp_lat);
    logic [8:0] e;
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    e = sb_q.pop_front();
    if (lat != 0) begin
      check({name, "_out"}, 32'(out), 32'(e[8:1]));
      check({name, "_borrow"}, 32'(borrow), 32'(e[0]));
    end
  endtask

  // Leave DONE: one en-high edge returns to IDLE.
  task automatic back_to_idle();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eo, input logic eb);
    int lat;
    @(negedge clk);
    a = av; b = bv; en = 1'b1;
    sb_q.push_back({sat_adj(eo, eb), eb});
    wait_done(20, lat);
    pop_and_compare(name, lat, 9);
    back_to_idle();
  endtask

  initial begin
    int lat;
    tests = 0;
    failures = 0;
    rst = 1'b0; en = 1'b0; a = '0; b = '0;

    vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1};
    vecs[2] = '{8'hAA,  8'hAA,  8'h00,  1'b0};
    vecs[3] = '{8'hFF,  8'h00,  8'hFF,  1'b0};
    vecs[4] = '{8'd10,  8'd3,   8'd7,   1'b0};
    vecs[5] = '{8'h00,  8'h01,  8'hFF,  1'b1};
    vecs[6] = '{8'h80,  8'h7F,  8'h01,  1'b0};
    vecs[7] = '{8'h00,  8'hFF,  8'h01,  1'b1};

    #12;
    check("reset_out", 32'(out), 32'h0);
    check("reset_borrow", 32'(borrow), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_borrow);

    // Abort: en dropped after edge 3 of SUB; 4 shifts of 100-1 leave 0x30.
    @(negedge clk); a = 8'd100; b = 8'd1; en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); en = 1'b0; a = 8'd0; b = 8'd0;
    begin
      int seen_done;
      seen_done = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (done) seen_done = 1;
      end
      check("abort_done_low", 32'(seen_done), 32'h0);
    end
    check("abort_partial_out", 32'(out), 32'h30);
    check("abort_partial_borrow", 32'(borrow), 32'h0);
    run_op("after_abort", 8'd10, 8'd3, 8'd7, 1'b0);

    // DONE hold for 5 cycles, then two en-high edges restart on new operands.
    @(negedge clk); a = 8'd200; b = 8'd55; en = 1'b1;
    sb_q.push_back({8'd145, 1'b0});
    wait_done(20, lat);
    pop_and_compare("hold_first", lat, 9);
    @(negedge clk); en = 1'b0; a = 8'd1; b = 8'd2;
    begin
      int stable;
      stable = 1;
      repeat (5) begin
        @(posedge clk); #1;
        if (out !== 8'd145 || borrow !== 1'b0 || done !== 1'b1) stable = 0;
      end
      check("done_hold_stable", 32'(stable), 32'h1);
    end
    @(negedge clk); en = 1'b1; a = 8'd12; b = 8'd5;
    sb_q.push_back({8'd7, 1'b0});
    @(posedge clk); #1;
    check("restart_done_clears", 32'(done), 32'h0);
    wait_done(20, lat);
    pop_and_compare("restart", lat, 9);
    back_to_idle();

    // Asynchronous reset mid-SUB, then a clean operation.
    @(negedge clk); a = 8'd50; b = 8'd20; en = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("pre_reset_partial", 32'(out), 32'hE0);
    rst = 1'b0;
    #1;
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_borrow", 32'(borrow), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    @(negedge clk); en = 1'b0; rst = 1'b1;
    run_op("after_reset", 8'd50, 8'd20, 8'd30, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
